// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, size/fault encodings and strobe mask helper for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} lsu_state_t;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam logic [1:0] FLT_NONE = 2'd0;
  localparam logic [1:0] FLT_MISALIGN = 2'd1;
  localparam logic [1:0] FLT_BUSERR = 2'd2;
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    return size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0F : 8'hFF;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: lane shifting of store data/strobes and right-alignment plus sign/zero extension of load data
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int LW = $clog2(NB)
) (
  input  logic [LW-1:0]     lane,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [NB-1:0]     wstrb_o,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] shifted, keep, msb;
  logic [6:0] nbits;
  logic sign;
  always_comb begin
    wdata_o = wdata_i << {lane, 3'b000};
    wstrb_o = NB'(size_mask(op[1:0])) << lane;
    shifted = rdata_i >> {lane, 3'b000};
    nbits = 7'd8 << op[1:0];
    // a shift by the full width yields 0, so keep becomes all ones for full-width loads
    keep = ~({DATA_W{1'b1}} << nbits);
    msb = {{(DATA_W-1){1'b0}}, 1'b1} << (nbits - 7'd1);
    sign = |(shifted & msb);
    rdata_o = (shifted & keep) | ((sign & ~op[2]) ? ~keep : '0);
  end
endmodule

// File: rtl/lsu_bus.sv
// lsu_bus: load/store unit bridging EXU and WBU over a variable-latency request/response memory port
module lsu_bus
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int PASS_W = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic                in_ren,
  input  logic                in_wen,
  input  logic [2:0]          in_op,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [PASS_W-1:0]   in_pass,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [DATA_W-1:0]   out_rdata,
  output logic [1:0]          out_fault,
  output logic [PASS_W-1:0]   out_pass,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  input  logic                mem_resp_err
);
  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  lsu_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic wen_q, wen_d;
  logic [2:0] op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, rdata_ext;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [1:0] fault_q, fault_d;
  logic [NB-1:0] wstrb_raw;
  logic accept, is_mem, misalign;
  lsu_align #(.DATA_W(DATA_W)) u_align (
    .lane    (addr_q[LW-1:0]),
    .op      (op_q),
    .wdata_i (wdata_q),
    .rdata_i (mem_resp_rdata),
    .wdata_o (mem_req_wdata),
    .wstrb_o (wstrb_raw),
    .rdata_o (rdata_ext)
  );
  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign out_valid = state_q == S_DONE;
  assign out_addr = addr_q;
  assign out_rdata = rdata_q;
  assign out_fault = fault_q;
  assign out_pass = pass_q;
  assign mem_req_valid = state_q == S_REQ;
  assign mem_req_addr = addr_q;
  assign mem_req_wen = wen_q;
  assign mem_req_wstrb = wen_q ? wstrb_raw : '0;
  always_comb begin
    accept = in_valid & in_ready;
    is_mem = in_ren | in_wen;
    // doubleword accesses cannot be served by a 32-bit port, so they are treated as misaligned
    misalign = (in_op[1:0] == SZ_H && in_addr[0]) ||
               (in_op[1:0] == SZ_W && in_addr[1:0] != 2'b00) ||
               (in_op[1:0] == SZ_D && (DATA_W == 32 || in_addr[2:0] != 3'b000));
    state_d = state_q;
    addr_d = addr_q;
    wen_d = wen_q;
    op_d = op_q;
    wdata_d = wdata_q;
    pass_d = pass_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    if (accept) begin
      addr_d = in_addr;
      wen_d = in_wen;
      op_d = in_op;
      wdata_d = in_wdata;
      pass_d = in_pass;
      rdata_d = '0;
      fault_d = (is_mem & misalign) ? FLT_MISALIGN : FLT_NONE;
      state_d = (is_mem & ~misalign) ? S_REQ : S_DONE;
    end else if (state_q == S_REQ && mem_req_ready) begin
      state_d = S_RESP;
    end else if (state_q == S_RESP && mem_resp_valid) begin
      state_d = S_DONE;
      fault_d = mem_resp_err ? FLT_BUSERR : FLT_NONE;
      rdata_d = (mem_resp_err | wen_q) ? '0 : rdata_ext;
    end else if (state_q == S_DONE && out_ready) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      wen_q <= 1'b0;
      op_q <= '0;
      wdata_q <= '0;
      pass_q <= '0;
      rdata_q <= '0;
      fault_q <= FLT_NONE;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wen_q <= wen_d;
      op_q <= op_d;
      wdata_q <= wdata_d;
      pass_q <= pass_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end
endmodule

// File: tb/tb_lsu_bus.sv
// tb_lsu_bus: scoreboard bench for lsu_bus with a stallable memory responder and WBU-side monitor
module tb_lsu_bus;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PW = 40;
  localparam int NB = DW / 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [AW-1:0] in_addr = '0;
  logic in_ren = 1'b0, in_wen = 1'b0;
  logic [2:0] in_op = '0;
  logic [DW-1:0] in_wdata = '0;
  logic [PW-1:0] in_pass = '0;
  logic out_valid, out_ready = 1'b1;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_rdata;
  logic [1:0] out_fault;
  logic [PW-1:0] out_pass;
  logic mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [NB-1:0] mem_req_wstrb;
  logic mem_resp_valid = 1'b0, mem_resp_err = 1'b0;
  logic [DW-1:0] mem_resp_rdata = '0;
  always #5 clk = ~clk;
  lsu_bus #(.ADDR_W(AW), .DATA_W(DW), .PASS_W(PW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_ren(in_ren),
    .in_wen(in_wen), .in_op(in_op), .in_wdata(in_wdata), .in_pass(in_pass),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_rdata(out_rdata), .out_fault(out_fault), .out_pass(out_pass),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_err(mem_resp_err)
  );
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic [1:0] fault;
    logic [PW-1:0] pass;
    int lat;
    int acc;
  } res_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic wen;
    logic [DW-1:0] wdata;
    logic [NB-1:0] wstrb;
  } req_t;
  res_t sb[$];
  req_t rq[$];
  res_t e_out;
  req_t e_req;
  int n_cmp = 0, n_err = 0, cyc = 0;
  int stall = 0, rsp_lat = 1, rsp_cnt = 0;
  logic [DW-1:0] rsp_rdata = '0;
  logic rsp_err = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // memory model: checks request fields every cycle they are presented, stalls, then responds
  always @(negedge clk) begin
    mem_resp_valid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rsp_rdata;
        mem_resp_err = rsp_err;
      end
    end
    mem_req_ready = 1'b0;
    if (rst === 1'b1 && mem_req_valid) begin
      if (rq.size() == 0) check("req_unexpected", 1, 0);
      else begin
        e_req = rq[0];
        check("req_addr", mem_req_addr, e_req.addr);
        check("req_wen", mem_req_wen, e_req.wen);
        check("req_wdata", mem_req_wdata, e_req.wdata);
        check("req_wstrb", mem_req_wstrb, e_req.wstrb);
      end
      if (stall > 0) stall--;
      else begin
        mem_req_ready = 1'b1;
        rsp_cnt = rsp_lat;
        if (rq.size() != 0) void'(rq.pop_front());
      end
    end
  end
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid) begin
      if (sb.size() == 0) check("out_unexpected", 1, 0);
      else begin
        e_out = sb[0];
        check("out_addr", out_addr, e_out.addr);
        check("out_rdata", out_rdata, e_out.rdata);
        check("out_fault", out_fault, e_out.fault);
        check("out_pass", out_pass, e_out.pass);
        if (out_ready) begin
          if (e_out.lat >= 0) check("latency", cyc - e_out.acc + 1, e_out.lat);
          void'(sb.pop_front());
        end
      end
    end
  end
  task automatic issue(input logic [AW-1:0] a, input logic ren, input logic wen, input logic [2:0] op,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input logic [1:0] exp_flt,
                       input int lat, input logic [DW-1:0] exp_wd, input logic [NB-1:0] exp_st);
    logic [63:0] r;
    int n;
    r = {$urandom(), $urandom()};
    n = 0;
    in_valid = 1'b1; in_addr = a; in_ren = ren; in_wen = wen; in_op = op; in_wdata = wd;
    in_pass = r[PW-1:0];
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back('{a, exp_rd, exp_flt, r[PW-1:0], lat, cyc});
    if ((ren | wen) && exp_flt != 2'd1) rq.push_back('{a, wen, exp_wd, exp_st});
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rq.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 64'(sb.size() + rq.size()), 0);
  endtask
  task automatic mem_op(input logic [AW-1:0] a, input logic wen, input logic [2:0] op, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rd, input logic err, input logic [DW-1:0] exp_rd,
                        input logic [1:0] exp_flt, input int lat, input logic [DW-1:0] exp_wd,
                        input logic [NB-1:0] exp_st);
    rsp_rdata = rd;
    rsp_err = err;
    issue(a, ~wen, wen, op, wd, exp_rd, exp_flt, lat, exp_wd, exp_st);
    drain();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_fault", out_fault, 0);
    check("rst_rdata", out_rdata, 0);
    check("rst_addr", out_addr, 0);
    check("rst_pass", out_pass, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    mem_op(32'h8000_0003, 0, 3'b000, 0, 32'h80AB_CDEF, 0, 32'hFFFF_FF80, 2'd0, 3, 0, 4'b0000);
    stall = 3;
    mem_op(32'h1000_0002, 1, 3'b001, 32'h0000_1234, 0, 0, 0, 2'd0, -1, 32'h1234_0000, 4'b1100);
    mem_op(32'h1000_0001, 0, 3'b010, 0, 0, 0, 0, 2'd1, 1, 0, 0);
    mem_op(32'h1000_0004, 0, 3'b011, 0, 0, 0, 0, 2'd1, 1, 0, 0);
    mem_op(32'h2000_0002, 0, 3'b101, 0, 32'h8001_0000, 1, 0, 2'd2, 3, 0, 4'b0000);
    mem_op(32'h2000_0002, 0, 3'b101, 0, 32'h8001_0000, 0, 32'h0000_8001, 2'd0, 3, 0, 4'b0000);
    mem_op(32'h2000_0000, 0, 3'b001, 0, 32'h1234_F00D, 0, 32'hFFFF_F00D, 2'd0, 3, 0, 4'b0000);
    mem_op(32'h2000_0001, 0, 3'b100, 0, 32'h0000_9A00, 0, 32'h0000_009A, 2'd0, 3, 0, 4'b0000);
    mem_op(32'h2000_0008, 0, 3'b010, 0, 32'h8765_4321, 0, 32'h8765_4321, 2'd0, 3, 0, 4'b0000);
    mem_op(32'h3000_0003, 1, 3'b000, 32'h0000_00AB, 0, 0, 0, 2'd0, 3, 32'hAB00_0000, 4'b1000);
    mem_op(32'h3000_0004, 1, 3'b010, 32'hDEAD_BEEF, 0, 1, 0, 2'd2, 3, 32'hDEAD_BEEF, 4'b1111);
    issue(32'h0000_0011, 0, 0, 3'b010, 0, 0, 2'd0, 1, 0, 0);
    issue(32'h0000_0022, 0, 0, 3'b010, 0, 0, 2'd0, 1, 0, 0);
    issue(32'h0000_0033, 0, 0, 3'b010, 0, 0, 2'd0, 1, 0, 0);
    drain();
    out_ready = 1'b0;
    issue(32'h0000_0044, 0, 0, 3'b001, 0, 0, 2'd0, -1, 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    drain();
    rsp_lat = 6;
    rsp_rdata = 32'h0000_0055;
    rsp_err = 1'b0;
    issue(32'h4000_0000, 1, 0, 3'b010, 0, 32'h55, 2'd0, -1, 0, 4'b0000);
    @(posedge clk); #1;
    check("resp_wait_req", mem_req_valid, 0);
    check("resp_wait_out", out_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    rq.delete();
    check("abort_in_ready", in_ready, 1);
    check("abort_req_valid", mem_req_valid, 0);
    repeat (8) begin
      @(posedge clk); #1;
      check("stray_out_valid", out_valid, 0);
    end
    rsp_lat = 1;
    mem_op(32'h4000_0004, 0, 3'b010, 0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 2'd0, 3, 0, 4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
